boot_loader_ctrl: RTL
=====================

Name: boot_loader_ctrl

Overview:
- UART boot sequencer between the UART receiver/transmitter and the FlexPRET instruction memory write port.
- Holds the core in reset and parses a framed program image from the UART byte stream: sync, 16-bit word count, little-endian 32-bit words, checksum.
- Writes each word into imem and answers ACK or NAK.
- On success it releases the core; on failure it keeps the core in reset and waits for a new frame.

Parameters:
- ADDR_W, 12, imem word-address width; capacity = 2^ADDR_W words.
- SYNC_BYTE, 8'hFE, frame start byte.
- ACK_BYTE, 8'h06, reply sent on successful load.
- NAK_BYTE, 8'h15, reply sent on any error.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  in  8  received UART byte.
- tx_ready  in  1  UART transmitter can accept a byte.
- tx_valid  out  1  reply byte valid; held until tx_ready.
- tx_data  out  8  reply byte.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- core_reset  out  1  active-high reset to the core; 1 until boot succeeds.
- boot_done  out  1  sticky 1 after a successful load.
- boot_error  out  1  1 while in ERR/NAK, until the next sync byte.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - core_reset=1; boot_done=0; boot_error=0; tx_valid=0; imem_we=0; imem_addr=0; tx_data=0; imem_wdata=0.
  - Checksum, byte-lane and word counters are cleared.
  - Reset mid-frame abandons the frame; words already written stay in imem.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, REPLY, RUN, ERR.
- IDLE:
  - Bytes other than SYNC_BYTE are ignored.
  - SYNC_BYTE -> LEN_LO; clear sum, addr and lane; clear boot_error.
- LEN_LO / LEN_HI:
  - Capture the 16-bit word count, little-endian.
  - In LEN_HI: count > 2^ADDR_W -> ERR; count == 0 -> CSUM; otherwise -> DATA.
- DATA:
  - 2-bit lane counter assembles bytes into the word; lane 0 is bits 7:0.
  - On the lane-3 byte, imem_we=1 for exactly the next cycle, with imem_addr = current word index and imem_wdata = assembled word.
  - Address then increments. After the last word -> CSUM.
- Checksum:
  - sum = 8-bit modular sum of every byte after sync (length, data, checksum byte).
  - In CSUM the received byte is added; a final sum of 0 means the frame is good.
  - Good -> REPLY with ACK; bad -> ERR.
- ERR:
  - Sets boot_error=1, loads NAK into the reply, goes to REPLY.
  - After NAK is accepted -> IDLE; core_reset stays 1.
- REPLY:
  - tx_valid=1 and tx_data stable until the cycle tx_ready=1, then tx_valid=0 on the next cycle.
  - After ACK -> RUN; after NAK -> IDLE.
  - rx bytes arriving in REPLY are dropped.
- RUN:
  - core_reset=0 and boot_done=1 from the cycle after the ACK handshake.
  - All rx ignored until reset.
- Timeout:
  - Counter clears on every rx_valid and increments otherwise in LEN_LO, LEN_HI, DATA and CSUM.
  - Reaching TIMEOUT_CYCLES -> ERR.
  - No timeout in IDLE, REPLY or RUN.
- Simultaneous events: rx_valid in the same cycle the timeout expires counts as a byte; the timeout does not fire.
- Words written before a checksum failure remain in imem; only core release is gated.

Decomposition:
- Shared package: state encoding, default SYNC/ACK/NAK byte constants, frame length-field width (16).
- One natural sub-module, boot_frame_csum: 8-bit running adder with clear/enable and zero-detect.
- Timeout counter and byte-lane assembler stay inline.

Test Plan:
- Frame FE 02 00 | 13 00 00 00 | 6F 00 00 00 | csum 0x7C, tx_ready=1:
  - imem writes addr0=0x00000013, addr1=0x0000006F.
  - tx_data=0x06; core_reset falls; boot_done=1.
- Same frame with csum 0x7D:
  - Both writes occur; NAK 0x15 sent; boot_error=1; core_reset stays 1.
  - A following correct frame -> ACK and release.
- Garbage 00 55 AA, then FE 00 00 00: zero-length frame, no imem_we, ACK.
- FE 01 10 (count 4097 with ADDR_W=12) -> immediate NAK; no writes.
- TIMEOUT_CYCLES=100; send FE 01 00 13, then idle 100 cycles -> NAK; no imem_we.
- reset=0 mid-DATA (after 2 of 4 bytes) -> all outputs at reset values next cycle; a subsequent full frame loads from addr 0.
- tx_ready held 0 for 20 cycles during REPLY -> tx_valid/tx_data stable; core_reset released only after the ACK handshake.

Source files
------------

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding,
// default framing bytes and the width of the frame length field.
package boot_loader_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    REPLY  = 3'd5,
    RUN    = 3'd6,
    ERR    = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hFE;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;
  localparam int unsigned LEN_W        = 16;

  function automatic logic in_frame(input state_e st);
    return (st == LEN_LO) || (st == LEN_HI) || (st == DATA) || (st == CSUM);
  endfunction

endpackage

// File: rtl/boot_frame_csum.sv
// 8-bit running modular sum of frame bytes with clear/enable and a
// zero-detect on the sum that would result from adding the current byte.
module boot_frame_csum (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic       next_zero
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic [7:0] sum_add;

  // next running sum
  always_comb begin
    sum_add = sum_q + din;
    if (clr) begin
      sum_d = 8'h00;
    end else if (en) begin
      sum_d = sum_add;
    end else begin
      sum_d = sum_q;
    end
  end

  // sum register
  always_ff @(posedge clock) begin
    if (!reset) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign next_zero = (sum_add == 8'h00);

endmodule

// File: rtl/boot_loader_ctrl.sv
// UART boot sequencer: parses sync/length/words/checksum frames, writes words
// into instruction memory, replies ACK or NAK and releases the core on success.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              boot_done,
  output logic              boot_error
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CAP   = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ack_q, ack_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_reset_q, core_reset_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_error_q, boot_error_d;

  logic              csum_clr, csum_en, csum_next_zero;
  logic [LEN_W-1:0]  len16;
  logic              tmo_hit;

  boot_frame_csum u_csum (
    .clock     (clock),
    .reset     (reset),
    .clr       (csum_clr),
    .en        (csum_en),
    .din       (rx_data),
    .next_zero (csum_next_zero)
  );

  assign len16   = {rx_data, len_lo_q};
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit = !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // frame parser next-state and output logic
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    lane_d       = lane_q;
    word_d       = word_q;
    ack_d        = ack_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_reset_d = core_reset_q;
    boot_done_d  = boot_done_q;
    boot_error_d = boot_error_q;
    csum_clr     = 1'b0;
    csum_en      = 1'b0;

    if (in_frame(state_q) && !rx_valid) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d      = LEN_LO;
          csum_clr     = 1'b1;
          word_idx_d   = '0;
          lane_d       = 2'd0;
          boot_error_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          csum_en  = 1'b1;
          state_d  = LEN_HI;
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          state_d = LEN_LO;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          csum_en = 1'b1;
          count_d = CNT_W'(len16);
          if ({16'h0000, len16} > CAP) begin
            state_d = ERR;
          end else if (len16 == 16'h0000) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          state_d = LEN_HI;
        end
      end
      DATA: begin
        if (rx_valid) begin
          csum_en = 1'b1;
          lane_d  = lane_q + 2'd1;
          case (lane_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_idx_q[ADDR_W-1:0];
              imem_wdata_d = {rx_data, word_q};
              word_idx_d   = word_idx_q + CNT_W'(1);
              if ((word_idx_q + CNT_W'(1)) == count_q) begin
                state_d = CSUM;
              end else begin
                state_d = DATA;
              end
            end
          endcase
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          state_d = DATA;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (csum_next_zero) begin
            state_d    = REPLY;
            ack_d      = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_BYTE;
          end else begin
            state_d = ERR;
          end
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          state_d = CSUM;
        end
      end
      ERR: begin
        boot_error_d = 1'b1;
        ack_d        = 1'b0;
        tx_valid_d   = 1'b1;
        tx_data_d    = NAK_BYTE;
        state_d      = REPLY;
      end
      REPLY: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (ack_q) begin
            state_d      = RUN;
            core_reset_d = 1'b0;
            boot_done_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = REPLY;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_lo_q     <= 8'h00;
      count_q      <= '0;
      word_idx_q   <= '0;
      lane_q       <= 2'd0;
      word_q       <= 24'h000000;
      tmo_q        <= '0;
      ack_q        <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h00000000;
      core_reset_q <= 1'b1;
      boot_done_q  <= 1'b0;
      boot_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      tmo_q        <= tmo_d;
      ack_q        <= ack_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
      boot_done_q  <= boot_done_d;
      boot_error_q <= boot_error_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign boot_done  = boot_done_q;
  assign boot_error = boot_error_q;

endmodule
